// File: rtl/instr_obi_arbiter.sv
// Two-requester OBI instruction-port arbiter.
// Requester 0 (prefetch) and requester 1 (debug/aux fetch) share one OBI
// port. Address phases are arbitrated round-robin, and a selection that has
// been presented without a grant stays locked until it is granted. Responses
// are routed back in order through an owner FIFO that records who was granted.
module instr_obi_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   // requester 0 (prefetch)
   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   // requester 1 (debug / aux fetch)
   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   // shared response path
   output logic [31:0]       rdata_o,
   output logic              err_o,
   // OBI memory side
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_gnt_i,
   input  logic              instr_rvalid_i,
   input  logic [31:0]       instr_rdata_i,
   input  logic              instr_err_i,
   // status
   output logic              busy_o,
   output logic              protocol_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   // FREE: selection follows round-robin; LOCKED: selection pinned to lock_id_q
   typedef enum logic {
      ST_FREE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   lock_state_e       state_q, state_d;
   logic              lock_id_q, lock_id_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic              perr_q, perr_d;
   logic              owner_q [MAX_OUTSTANDING];

   logic              rr_id;
   logic              sel_id;
   logic              sel_req;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              push;
   logic              head_id;

   assign fifo_full  = (count_q == CNT_MAX);
   assign fifo_empty = (count_q == '0);
   assign head_id    = owner_q[rptr_q];

   // A response is only consumed when someone is waiting for it
   assign pop  = instr_rvalid_i & ~fifo_empty;
   assign push = instr_req_o & instr_gnt_i;

   // Round-robin pick used whenever the selection is not locked
   always_comb begin
      rr_id = ~last_q;
      if (m0_req_i && m1_req_i) begin
         rr_id = ~last_q;
      end else if (m0_req_i) begin
         rr_id = 1'b0;
      end else if (m1_req_i) begin
         rr_id = 1'b1;
      end
   end

   // Lock state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FREE;
         lock_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end

   // Lock next-state: lock on an ungranted request, release on grant or withdrawal
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      case (state_q)
         ST_FREE: begin
            lock_id_d = sel_id;
            if (instr_req_o && !instr_gnt_i) begin
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (push || !sel_req) begin
               state_d = ST_FREE;
            end
         end
         default: begin
            state_d = ST_FREE;
         end
      endcase
   end

   // Lock outputs: selection, address phase, grant and response routing
   always_comb begin
      sel_id       = (state_q == ST_LOCKED) ? lock_id_q : rr_id;
      sel_req      = sel_id ? m1_req_i : m0_req_i;
      instr_req_o  = sel_req & (~fifo_full | pop);
      instr_addr_o = sel_id ? m1_addr_i : m0_addr_i;
      m0_gnt_o     = instr_gnt_i & instr_req_o & ~sel_id;
      m1_gnt_o     = instr_gnt_i & instr_req_o &  sel_id;
      m0_rvalid_o  = pop & ~head_id;
      m1_rvalid_o  = pop &  head_id;
   end

   assign rdata_o        = instr_rdata_i;
   assign err_o          = instr_err_i;
   assign busy_o         = (count_q != '0) | m0_req_i | m1_req_i;
   assign protocol_err_o = perr_q;

   // Bookkeeping next-state: last-granted, occupancy, pointers, sticky error
   always_comb begin
      last_d  = last_q;
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      perr_d  = perr_q;
      if (push) begin
         last_d = sel_id;
         wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (instr_rvalid_i && fifo_empty) begin
         perr_d = 1'b1;
      end
   end

   // Control registers; last-granted resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q  <= 1'b1;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         last_q  <= last_d;
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         perr_q  <= perr_d;
      end
   end

   // Owner FIFO storage; validity is tracked by count_q so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         owner_q[wptr_q] <= sel_id;
      end
   end

endmodule

// File: tb/tb_instr_obi_arbiter.sv
// Scoreboard bench for instr_obi_arbiter: directed vectors push expected
// grants/responses into queues, a negedge monitor pops and compares.
module tb_instr_obi_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
   logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   logic        busy_o, protocol_err_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        id;
      logic [31:0] addr;
   } gnt_exp_t;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        err;
   } rsp_exp_t;

   gnt_exp_t gq[$];
   rsp_exp_t rq[$];

   instr_obi_arbiter #(
      .MAX_OUTSTANDING(2),
      .ADDR_W(32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .m0_req_i      (m0_req_i),
      .m0_addr_i     (m0_addr_i),
      .m0_gnt_o      (m0_gnt_o),
      .m0_rvalid_o   (m0_rvalid_o),
      .m1_req_i      (m1_req_i),
      .m1_addr_i     (m1_addr_i),
      .m1_gnt_o      (m1_gnt_o),
      .m1_rvalid_o   (m1_rvalid_o),
      .rdata_o       (rdata_o),
      .err_o         (err_o),
      .instr_req_o   (instr_req_o),
      .instr_addr_o  (instr_addr_o),
      .instr_gnt_i   (instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i),
      .instr_rdata_i (instr_rdata_i),
      .instr_err_i   (instr_err_i),
      .busy_o        (busy_o),
      .protocol_err_o(protocol_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic exp_g(input logic id, input logic [31:0] addr);
      gnt_exp_t e;
      e.id = id;
      e.addr = addr;
      gq.push_back(e);
   endtask

   task automatic exp_r(input logic id, input logic [31:0] data, input logic err);
      rsp_exp_t e;
      e.id = id;
      e.data = data;
      e.err = err;
      rq.push_back(e);
   endtask

   // one cycle: inputs change 1 time unit after the edge, returns 3 units after
   task automatic drive(input logic r0, input logic [31:0] a0,
                        input logic r1, input logic [31:0] a1,
                        input logic g, input logic rv,
                        input logic [31:0] rd, input logic er);
      @(posedge clk);
      #1;
      m0_req_i       = r0;
      m0_addr_i      = a0;
      m1_req_i       = r1;
      m1_addr_i      = a1;
      instr_gnt_i    = g;
      instr_rvalid_i = rv;
      instr_rdata_i  = rd;
      instr_err_i    = er;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // monitor: every grant / response presented by the DUT is matched to the queue head
   always @(negedge clk) begin
      if (m0_gnt_o || m1_gnt_o) begin
         chk("gnt_onehot", {31'b0, m0_gnt_o & m1_gnt_o}, 32'h0);
         if (gq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_gnt m0=%0b m1=%0b addr=%h expected=none", m0_gnt_o, m1_gnt_o, instr_addr_o);
         end else begin
            gnt_exp_t e;
            e = gq.pop_front();
            chk("gnt_id", {31'b0, m1_gnt_o}, {31'b0, e.id});
            chk("gnt_addr", instr_addr_o, e.addr);
         end
      end
      if (m0_rvalid_o || m1_rvalid_o) begin
         chk("rsp_onehot", {31'b0, m0_rvalid_o & m1_rvalid_o}, 32'h0);
         if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid m0=%0b m1=%0b data=%h expected=none", m0_rvalid_o, m1_rvalid_o, rdata_o);
         end else begin
            rsp_exp_t e;
            e = rq.pop_front();
            chk("rsp_id", {31'b0, m1_rvalid_o}, {31'b0, e.id});
            chk("rsp_data", rdata_o, e.data);
            chk("rsp_err", {31'b0, err_o}, {31'b0, e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      idle();
      idle();
      chk("rst_req", {31'b0, instr_req_o}, 32'h0);
      chk("rst_busy", {31'b0, busy_o}, 32'h0);
      chk("rst_perr", {31'b0, protocol_err_o}, 32'h0);
      chk("rst_gnt", {30'b0, m0_gnt_o, m1_gnt_o}, 32'h0);
      drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("rst_busy_req", {31'b0, busy_o}, 32'h1);
      idle();
      rst = 1'b0;
      idle();

      // round-robin with gnt every cycle: 0x100, 0x200, 0x100
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h100);
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h11, 1'b0);
      exp_g(1'b1, 32'h200); exp_r(1'b0, 32'h11, 1'b0);
      drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h22, 1'b0);
      exp_g(1'b0, 32'h100); exp_r(1'b1, 32'h22, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33, 1'b1);
      exp_r(1'b0, 32'h33, 1'b1);
      idle();
      chk("rr_busy_idle", {31'b0, busy_o}, 32'h0);

      // lock: m0 at 0x40 held ungranted while m1 requests
      drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("lock_addr0", instr_addr_o, 32'h40);
      chk("lock_req0", {31'b0, instr_req_o}, 32'h1);
      drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("lock_addr1", instr_addr_o, 32'h40);
      drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("lock_addr2", instr_addr_o, 32'h40);
      drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h40);
      drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b1, 32'h80);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0, 1'b0);
      exp_r(1'b0, 32'hA0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA1, 1'b0);
      exp_r(1'b1, 32'hA1, 1'b0);

      // full: two outstanding blocks a third, grant+rvalid same cycle accepted
      drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h300);
      drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h300);
      drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("full_req", {31'b0, instr_req_o}, 32'h0);
      chk("full_gnt", {30'b0, m0_gnt_o, m1_gnt_o}, 32'h0);
      chk("full_busy", {31'b0, busy_o}, 32'h1);
      drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB0, 1'b0);
      chk("full_pop_req", {31'b0, instr_req_o}, 32'h1);
      exp_g(1'b0, 32'h300); exp_r(1'b0, 32'hB0, 1'b0);
      drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("still_full_req", {31'b0, instr_req_o}, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB1, 1'b0);
      exp_r(1'b0, 32'hB1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB2, 1'b0);
      exp_r(1'b0, 32'hB2, 1'b0);

      // in-order routing: grants m0, m1, m0 -> rdata 0xA, 0xB, 0xC
      drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h500);
      drive(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b1, 32'h600);
      drive(1'b1, 32'h504, 1'b0, 32'h0, 1'b1, 1'b1, 32'hA, 1'b0);
      exp_g(1'b0, 32'h504); exp_r(1'b0, 32'hA, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB, 1'b0);
      exp_r(1'b1, 32'hB, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0);
      exp_r(1'b0, 32'hC, 1'b0);
      idle();
      chk("inorder_busy", {31'b0, busy_o}, 32'h0);

      // stray rvalid on empty FIFO sets sticky protocol error
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
      chk("stray_rvalid", {30'b0, m0_rvalid_o, m1_rvalid_o}, 32'h0);
      chk("stray_perr_pre", {31'b0, protocol_err_o}, 32'h0);
      idle();
      chk("stray_perr_set", {31'b0, protocol_err_o}, 32'h1);
      idle();
      idle();
      chk("stray_perr_hold", {31'b0, protocol_err_o}, 32'h1);

      // reset with one outstanding
      drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h700);
      rst = 1'b1;
      idle();
      chk("midrst_busy", {31'b0, busy_o}, 32'h0);
      chk("midrst_perr", {31'b0, protocol_err_o}, 32'h0);
      rst = 1'b0;
      idle();
      chk("postrst_busy", {31'b0, busy_o}, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hEE, 1'b0);
      chk("postrst_rvalid", {30'b0, m0_rvalid_o, m1_rvalid_o}, 32'h0);
      idle();
      chk("postrst_perr", {31'b0, protocol_err_o}, 32'h1);
      drive(1'b1, 32'h800, 1'b1, 32'h900, 1'b1, 1'b0, 32'h0, 1'b0);
      exp_g(1'b0, 32'h800);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 1'b0);
      exp_r(1'b0, 32'hC0, 1'b0);
      idle();
      idle();

      chk("gnt_queue_drained", gq.size(), 32'h0);
      chk("rsp_queue_drained", rq.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
